// File: rtl/demux8_sequencer_pkg.sv
// Shared definitions for the demux8 control path: select width, channel count,
// FSM encoding and the mask helpers used to derive the first/last enabled channel.
package demux8_sequencer_pkg;

  localparam int SEL_W = 3;
  localparam int NCH   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] first_ch(input logic [NCH-1:0] mask);
    first_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) first_ch = SEL_W'(i);
    end
  endfunction

  function automatic logic [SEL_W-1:0] last_ch(input logic [NCH-1:0] mask);
    last_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mask[i]) last_ch = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/demux_next_ch.sv
// Round-robin channel step: next enabled channel strictly above ch, wrapping
// past the top. With only ch enabled the result is ch itself.
module demux_next_ch
  import demux8_sequencer_pkg::*;
(
  input  logic [SEL_W-1:0] ch,
  input  logic [NCH-1:0]   mask,
  output logic [SEL_W-1:0] next
);

  logic [SEL_W-1:0] idx;

  // Scan farthest-first so the nearest enabled channel wins.
  always_comb begin
    next = ch;
    idx  = ch;
    for (int k = NCH - 1; k >= 1; k--) begin
      idx = ch + SEL_W'(k);
      if (mask[idx]) next = idx;
    end
  end

endmodule

// File: rtl/demux8_sequencer.sv
// Serial-to-demux8 sequencer: accepts one bit per handshake, holds it with its
// channel select for DWELL cycles, and walks the enabled channels round-robin.
module demux8_sequencer
  import demux8_sequencer_pkg::*;
#(
  parameter logic [NCH-1:0] CH_MASK = 8'hFF,
  parameter int             DWELL   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic a,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic out_valid,
  output logic frame_done
);

  localparam logic [SEL_W-1:0] FIRST_CH   = first_ch(CH_MASK);
  localparam logic [SEL_W-1:0] LAST_CH    = last_ch(CH_MASK);
  localparam logic [7:0]       DWELL_INIT = 8'(DWELL - 1);

  generate
    if (CH_MASK == '0) begin : g_bad_mask
      $error("demux8_sequencer: CH_MASK must enable at least one channel");
    end
    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
      $error("demux8_sequencer: DWELL must be in 1..255");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ch, ch_next, sel;
  logic [7:0]       dwell_cnt;
  logic             last_cycle;

  demux_next_ch u_next_ch (
    .ch   (ch),
    .mask (CH_MASK),
    .next (ch_next)
  );

  assign last_cycle   = (state == ST_HOLD) && (dwell_cnt == 8'd0);
  assign {s2, s1, s0} = sel;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !sync;
        if (in_valid && !sync) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (dwell_cnt == 8'd0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // An aborted or reset frame never reports completion.
    frame_done = last_cycle && (ch == LAST_CH) && !sync && rst_n;
    if (sync) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a         <= 1'b0;
      sel       <= FIRST_CH;
      ch        <= FIRST_CH;
      out_valid <= 1'b0;
      dwell_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (sync) begin
        out_valid <= 1'b0;
        ch        <= FIRST_CH;
        dwell_cnt <= 8'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_valid) begin
              a         <= in_bit;
              sel       <= ch;
              out_valid <= 1'b1;
              dwell_cnt <= DWELL_INIT;
            end
          end
          ST_HOLD: begin
            if (dwell_cnt == 8'd0) begin
              out_valid <= 1'b0;
              ch        <= ch_next;
            end else begin
              dwell_cnt <= dwell_cnt - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
